// File: rtl/unidade_busca.sv
// -----------------------------------------------------------------------------
// unidade_busca -- instruction fetch unit
//
// Fetches one 16-bit instruction word per EscIR request, holds it in IR and
// owns the program counter. A fetch presents PC on mem_addr with mem_req high
// until mem_ack returns the word; if no ack arrives within 15 wait cycles the
// fetch is abandoned and the sticky erro flag is raised.
//
// Ports
//   clk           in   system clock, rising edge
//   rst           in   asynchronous active-high reset
//   EscIR         in   fetch request (ignored while a fetch is in progress)
//   EscCP         in   unconditional PC write
//   EscCondCP     in   conditional PC write (branch opcodes 4'hB / 4'hC)
//   FonteCP       in   PC source: 0 = ula_resultado, 1 = IR[7:0]
//   ula_resultado in   ALU result (PC+1 or branch target)
//   ula_zero      in   ALU zero flag
//   mem_req       out  instruction memory read request
//   mem_addr      out  instruction memory address, latched at fetch start
//   mem_ack       in   read data valid strobe
//   mem_dado      in   instruction word from memory
//   IR            out  instruction register
//   opcode        out  IR[15:12]
//   PC            out  program counter
//   pronto        out  one-cycle pulse, new instruction in IR
//   erro          out  sticky fetch-timeout flag
// -----------------------------------------------------------------------------
module unidade_busca (
    input  logic        clk,
    input  logic        rst,
    input  logic        EscIR,
    input  logic        EscCP,
    input  logic        EscCondCP,
    input  logic        FonteCP,
    input  logic [7:0]  ula_resultado,
    input  logic        ula_zero,
    output logic        mem_req,
    output logic [7:0]  mem_addr,
    input  logic        mem_ack,
    input  logic [15:0] mem_dado,
    output logic [15:0] IR,
    output logic [3:0]  opcode,
    output logic [7:0]  PC,
    output logic        pronto,
    output logic        erro
);

    typedef enum logic [1:0] {
        OCIOSO,
        BUSCA,
        CARREGADO
    } estado_t;

    // Branch-if-zero and branch-if-not-zero opcodes.
    localparam logic [3:0] OpBeq = 4'hB;
    localparam logic [3:0] OpBne = 4'hC;

    // Counter value seen in the 15th wait cycle; no ack there means timeout.
    localparam logic [3:0] TimeoutUltimo = 4'd14;

    estado_t     r_estado;
    logic [3:0]  r_timeout;
    logic        r_mem_req;
    logic [7:0]  r_mem_addr;
    logic [15:0] r_ir;
    logic [7:0]  r_pc;
    logic        r_pronto;
    logic        r_erro;

    logic        w_desvio_tomado;
    logic        w_pc_escreve;
    logic [7:0]  w_pc_prox;

    // ------------------------------------------------------------------
    // Fetch FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_estado   <= OCIOSO;
            r_timeout  <= 4'd0;
            r_mem_req  <= 1'b0;
            r_mem_addr <= 8'h00;
            r_ir       <= 16'h0000;
            r_pronto   <= 1'b0;
            r_erro     <= 1'b0;
        end else begin
            r_pronto <= 1'b0;
            case (r_estado)
                OCIOSO: begin
                    if (EscIR) begin
                        // Latches the PC value before any same-cycle PC write.
                        r_estado   <= BUSCA;
                        r_mem_req  <= 1'b1;
                        r_mem_addr <= r_pc;
                        r_timeout  <= 4'd0;
                    end
                end
                BUSCA: begin
                    if (mem_ack) begin
                        // Ack takes priority over a timeout in the same cycle.
                        r_ir      <= mem_dado;
                        r_mem_req <= 1'b0;
                        r_pronto  <= 1'b1;
                        r_estado  <= CARREGADO;
                    end else if (r_timeout == TimeoutUltimo) begin
                        r_mem_req <= 1'b0;
                        r_erro    <= 1'b1;
                        r_estado  <= OCIOSO;
                    end else begin
                        r_timeout <= r_timeout + 4'd1;
                    end
                end
                CARREGADO: begin
                    // pronto is high for this single cycle; EscIR is ignored.
                    r_estado <= OCIOSO;
                end
                default: begin
                    r_estado <= OCIOSO;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Program counter, writable in every FSM state
    // ------------------------------------------------------------------
    always_comb begin
        w_desvio_tomado = ((r_ir[15:12] == OpBeq) &&  ula_zero) ||
                          ((r_ir[15:12] == OpBne) && !ula_zero);
        w_pc_escreve    = EscCP || (EscCondCP && w_desvio_tomado);
        w_pc_prox       = FonteCP ? r_ir[7:0] : ula_resultado;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc <= 8'h00;
        end else if (w_pc_escreve) begin
            r_pc <= w_pc_prox;
        end
    end

    assign mem_req  = r_mem_req;
    assign mem_addr = r_mem_addr;
    assign IR       = r_ir;
    assign opcode   = r_ir[15:12];
    assign PC       = r_pc;
    assign pronto   = r_pronto;
    assign erro     = r_erro;

endmodule
